// File: rtl/writeback_arbiter.sv
// Writeback arbiter: merges a buffered ALU result stream and an unbuffered
// load result stream onto a single register-file write port.
//
// There is no sequencing FSM here. The only decision state is:
//   state      | meaning
//   count      | ALU results waiting in the 2-entry FIFO (0..2)
//   starve_cnt | consecutive LSU grants while ALU entries wait (0..AGE_LIMIT)
//
// LSU normally wins the write port. Once starve_cnt reaches AGE_LIMIT, the ALU
// head takes the next slot, so a streaming LSU cannot lock out ALU results.
module writeback_arbiter #(
  parameter int AGE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid,
  output logic        alu_ready,
  input  logic [4:0]  alu_rd,
  input  logic [63:0] alu_data,
  input  logic        lsu_valid,
  output logic        lsu_ready,
  input  logic [4:0]  lsu_rd,
  input  logic [63:0] lsu_data,
  output logic [4:0]  rd_addr,
  output logic [63:0] rd_data,
  output logic        rd_wen,
  output logic        busy
);

  localparam logic [3:0] AGE_MAX = 4'(AGE_LIMIT);

  logic [1:0]  count;
  logic [3:0]  starve_cnt;
  logic [4:0]  e0_rd;
  logic [4:0]  e1_rd;
  logic [63:0] e0_data;
  logic [63:0] e1_data;

  logic       alu_cand;
  logic       lsu_cand;
  logic       alu_prio;
  logic       grant_alu;
  logic       grant_lsu;
  logic       alu_enq;
  logic [1:0] cnt_after_deq;

  // Candidate selection and handshakes. Writes to x0 never compete for the port.
  assign alu_cand  = (count != 2'd0);
  assign lsu_cand  = lsu_valid && (lsu_rd != 5'd0);
  assign alu_prio  = (starve_cnt == AGE_MAX);

  assign grant_lsu = !rst && lsu_cand && !(alu_cand && alu_prio);
  assign grant_alu = !rst && alu_cand && (!lsu_cand || alu_prio);

  // Full FIFO refuses new results even when the head leaves this cycle,
  // which keeps alu_ready purely a function of registered state.
  assign alu_ready = !rst && (count != 2'd2);
  assign lsu_ready = !rst && ((lsu_rd == 5'd0) || !(alu_cand && alu_prio));

  assign alu_enq       = alu_valid && alu_ready && (alu_rd != 5'd0);
  assign cnt_after_deq = count - {1'b0, grant_alu};

  assign busy = (count != 2'd0);

  // ALU FIFO: entry 0 is the head; a dequeue shifts entry 1 down, and a new
  // result lands in the first slot free after that shift.
  always_ff @(posedge clk) begin
    if (rst) begin
      count   <= 2'd0;
      e0_rd   <= 5'd0;
      e0_data <= 64'd0;
      e1_rd   <= 5'd0;
      e1_data <= 64'd0;
    end else begin
      if (grant_alu) begin
        e0_rd   <= e1_rd;
        e0_data <= e1_data;
      end
      if (alu_enq) begin
        if (cnt_after_deq == 2'd0) begin
          e0_rd   <= alu_rd;
          e0_data <= alu_data;
        end else begin
          e1_rd   <= alu_rd;
          e1_data <= alu_data;
        end
      end
      count <= cnt_after_deq + {1'b0, alu_enq};
    end
  end

  // Starvation age: counts LSU wins only while ALU work is actually waiting.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= 4'd0;
    end else if ((count == 2'd0) || grant_alu) begin
      starve_cnt <= 4'd0;
    end else if (grant_lsu && (starve_cnt != AGE_MAX)) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

  // Registered write port: the granted result appears one edge after grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_wen  <= 1'b0;
      rd_addr <= 5'd0;
      rd_data <= 64'd0;
    end else if (grant_lsu) begin
      rd_wen  <= 1'b1;
      rd_addr <= lsu_rd;
      rd_data <= lsu_data;
    end else if (grant_alu) begin
      rd_wen  <= 1'b1;
      rd_addr <= e0_rd;
      rd_data <= e0_data;
    end else begin
      rd_wen  <= 1'b0;
      rd_addr <= 5'd0;
      rd_data <= 64'd0;
    end
  end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Bench for writeback_arbiter: directed scenarios with a write scoreboard.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the
// falling edge. Expected writes are queued in grant order as stimulus is
// driven and popped whenever rd_wen is seen high.
module tb_writeback_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        alu_valid = 1'b0;
  logic        alu_ready;
  logic [4:0]  alu_rd = 5'd0;
  logic [63:0] alu_data = 64'd0;
  logic        lsu_valid = 1'b0;
  logic        lsu_ready;
  logic [4:0]  lsu_rd = 5'd0;
  logic [63:0] lsu_data = 64'd0;
  logic [4:0]  rd_addr;
  logic [63:0] rd_data;
  logic        rd_wen;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic [4:0]  rd;
    logic [63:0] data;
  } wr_t;

  wr_t sb[$];

  writeback_arbiter #(.AGE_LIMIT(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .alu_valid (alu_valid),
    .alu_ready (alu_ready),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .lsu_valid (lsu_valid),
    .lsu_ready (lsu_ready),
    .lsu_rd    (lsu_rd),
    .lsu_data  (lsu_data),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_wen    (rd_wen),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Called at the falling edge: retire any write against the scoreboard,
  // then advance to just after the next rising edge.
  task automatic end_cycle();
    wr_t e;
    if (rd_wen) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL sb_unexpected_write: got rd=%0d data=%h, expected no write", rd_addr, rd_data);
      end else begin
        e = sb.pop_front();
        if (rd_addr !== e.rd || rd_data !== e.data) begin
          n_err++;
          $display("FAIL sb_write: got rd=%0d data=%h, expected rd=%0d data=%h",
                   rd_addr, rd_data, e.rd, e.data);
        end
      end
      n_cmp++;
      if (rd_addr === 5'd0) begin
        n_err++;
        $display("FAIL x0_write: rd_wen high with rd_addr=0");
      end
    end else begin
      n_cmp++;
      if (rd_addr !== 5'd0 || rd_data !== 64'd0) begin
        n_err++;
        $display("FAIL idle_outputs: got rd=%0d data=%h, expected 0/0", rd_addr, rd_data);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alu_valid = 1'b0;
    alu_rd    = 5'd0;
    alu_data  = 64'd0;
    lsu_valid = 1'b0;
    lsu_rd    = 5'd0;
    lsu_data  = 64'd0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 64'h1;
    lsu_valid = 1'b1; lsu_rd = 5'd2; lsu_data = 64'h2;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_cmp++;
      if (alu_ready !== 1'b0 || lsu_ready !== 1'b0 || rd_wen !== 1'b0 || busy !== 1'b0) begin
        n_err++;
        $display("FAIL reset_hold: got alu_ready=%b lsu_ready=%b rd_wen=%b busy=%b, expected 0 0 0 0",
                 alu_ready, lsu_ready, rd_wen, busy);
      end
      end_cycle();
    end
    rst = 1'b0;
    idle_inputs();
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || rd_wen !== 1'b0 || alu_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_release: got busy=%b rd_wen=%b alu_ready=%b, expected 0 0 1",
               busy, rd_wen, alu_ready);
    end
    end_cycle();
  endtask

  task automatic test_alu_only();
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 64'h1111;
    @(negedge clk);
    n_cmp++;
    if (alu_ready !== 1'b1) begin
      n_err++;
      $display("FAIL alu_only_accept: got alu_ready=%b, expected 1", alu_ready);
    end
    sb.push_back('{rd: 5'd5, data: 64'h1111});
    end_cycle();
    idle_inputs();
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1 || rd_wen !== 1'b0) begin
      n_err++;
      $display("FAIL alu_only_c1: got busy=%b rd_wen=%b, expected 1 0", busy, rd_wen);
    end
    end_cycle();
    @(negedge clk);
    n_cmp++;
    if (rd_wen !== 1'b1 || rd_addr !== 5'd5 || rd_data !== 64'h1111 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL alu_only_c2: got wen=%b rd=%0d data=%h busy=%b, expected 1 5 1111 0",
               rd_wen, rd_addr, rd_data, busy);
    end
    end_cycle();
  endtask

  task automatic test_collision();
    alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 64'h77;
    @(negedge clk);
    end_cycle();
    idle_inputs();
    lsu_valid = 1'b1; lsu_rd = 5'd3; lsu_data = 64'hAA;
    @(negedge clk);
    n_cmp++;
    if (lsu_ready !== 1'b1) begin
      n_err++;
      $display("FAIL collision_lsu_ready: got %b, expected 1", lsu_ready);
    end
    sb.push_back('{rd: 5'd3, data: 64'hAA});
    sb.push_back('{rd: 5'd7, data: 64'h77});
    end_cycle();
    idle_inputs();
    @(negedge clk);
    n_cmp++;
    if (rd_wen !== 1'b1 || rd_addr !== 5'd3) begin
      n_err++;
      $display("FAIL collision_first: got wen=%b rd=%0d, expected 1 3", rd_wen, rd_addr);
    end
    end_cycle();
    @(negedge clk);
    n_cmp++;
    if (rd_wen !== 1'b1 || rd_addr !== 5'd7) begin
      n_err++;
      $display("FAIL collision_second: got wen=%b rd=%0d, expected 1 7", rd_wen, rd_addr);
    end
    end_cycle();
    @(negedge clk);
    end_cycle();
  endtask

  task automatic test_starvation();
    logic [63:0] d;
    alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 64'h44;
    @(negedge clk);
    end_cycle();
    idle_inputs();
    d = 64'h900;
    lsu_valid = 1'b1; lsu_rd = 5'd9;
    for (int k = 1; k <= 6; k++) begin
      if (k != 6) d = 64'h900 + 64'(k);
      lsu_data = d;
      @(negedge clk);
      n_cmp++;
      if (lsu_ready !== (k != 5)) begin
        n_err++;
        $display("FAIL starve_lsu_ready_c%0d: got %b, expected %b", k, lsu_ready, (k != 5));
      end
      if (k == 5) sb.push_back('{rd: 5'd4, data: 64'h44});
      else        sb.push_back('{rd: 5'd9, data: d});
      if (k == 6) begin
        n_cmp++;
        if (rd_wen !== 1'b1 || rd_addr !== 5'd4) begin
          n_err++;
          $display("FAIL starve_alu_slot: got wen=%b rd=%0d, expected 1 4", rd_wen, rd_addr);
        end
      end
      end_cycle();
    end
    idle_inputs();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      end_cycle();
    end
  endtask

  task automatic test_full_fifo();
    logic       exp_alu_rdy [7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic       exp_lsu_rdy [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [4:0] alu_rds     [7] = '{5'd10, 5'd12, 5'd13, 5'd13, 5'd13, 5'd13, 5'd13};
    logic [63:0] ld;
    ld = 64'hB00;
    for (int c = 0; c < 7; c++) begin
      alu_valid = 1'b1;
      alu_rd    = alu_rds[c];
      alu_data  = 64'hA00 + 64'(alu_rds[c]);
      lsu_valid = 1'b1;
      lsu_rd    = 5'd11;
      lsu_data  = ld;
      @(negedge clk);
      n_cmp++;
      if (alu_ready !== exp_alu_rdy[c] || lsu_ready !== exp_lsu_rdy[c]) begin
        n_err++;
        $display("FAIL full_ready_c%0d: got alu_ready=%b lsu_ready=%b, expected %b %b",
                 c, alu_ready, lsu_ready, exp_alu_rdy[c], exp_lsu_rdy[c]);
      end
      if (exp_lsu_rdy[c]) begin
        sb.push_back('{rd: 5'd11, data: ld});
        ld = ld + 64'd1;
      end else begin
        sb.push_back('{rd: 5'd10, data: 64'hA0A});
      end
      end_cycle();
    end
    sb.push_back('{rd: 5'd12, data: 64'hA0C});
    sb.push_back('{rd: 5'd13, data: 64'hA0D});
    idle_inputs();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      end_cycle();
    end
  endtask

  task automatic test_x0();
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 64'h5;
    lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_data = 64'h6;
    @(negedge clk);
    n_cmp++;
    if (alu_ready !== 1'b1 || lsu_ready !== 1'b1) begin
      n_err++;
      $display("FAIL x0_accept: got alu_ready=%b lsu_ready=%b, expected 1 1", alu_ready, lsu_ready);
    end
    end_cycle();
    idle_inputs();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_cmp++;
      if (busy !== 1'b0 || rd_wen !== 1'b0) begin
        n_err++;
        $display("FAIL x0_discard_c%0d: got busy=%b rd_wen=%b, expected 0 0", c, busy, rd_wen);
      end
      end_cycle();
    end
    alu_valid = 1'b1; alu_rd = 5'd6; alu_data = 64'h66;
    sb.push_back('{rd: 5'd6, data: 64'h66});
    @(negedge clk);
    end_cycle();
    idle_inputs();
    lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_data = 64'h7;
    @(negedge clk);
    n_cmp++;
    if (lsu_ready !== 1'b1) begin
      n_err++;
      $display("FAIL x0_lsu_with_alu: got lsu_ready=%b, expected 1", lsu_ready);
    end
    end_cycle();
    idle_inputs();
    @(negedge clk);
    n_cmp++;
    if (rd_wen !== 1'b1 || rd_addr !== 5'd6) begin
      n_err++;
      $display("FAIL x0_alu_shared_slot: got wen=%b rd=%0d, expected 1 6", rd_wen, rd_addr);
    end
    end_cycle();
  endtask

  task automatic test_reset_mid();
    alu_valid = 1'b1; alu_rd = 5'd21; alu_data = 64'h210;
    lsu_valid = 1'b1; lsu_rd = 5'd20; lsu_data = 64'h200;
    sb.push_back('{rd: 5'd20, data: 64'h200});
    @(negedge clk);
    end_cycle();
    alu_rd = 5'd22; alu_data = 64'h220; lsu_data = 64'h201;
    sb.push_back('{rd: 5'd20, data: 64'h201});
    @(negedge clk);
    end_cycle();
    rst = 1'b1;
    alu_valid = 1'b0;
    lsu_valid = 1'b1; lsu_rd = 5'd25; lsu_data = 64'h250;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1 || alu_ready !== 1'b0 || lsu_ready !== 1'b0) begin
      n_err++;
      $display("FAIL rstmid_during: got busy=%b alu_ready=%b lsu_ready=%b, expected 1 0 0",
               busy, alu_ready, lsu_ready);
    end
    end_cycle();
    rst = 1'b0;
    idle_inputs();
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || rd_wen !== 1'b0 || alu_ready !== 1'b1) begin
      n_err++;
      $display("FAIL rstmid_after: got busy=%b rd_wen=%b alu_ready=%b, expected 0 0 1",
               busy, rd_wen, alu_ready);
    end
    end_cycle();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      end_cycle();
    end
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    @(posedge clk);
    #1;
    test_reset();
    test_alu_only();
    test_collision();
    test_starvation();
    test_full_fifo();
    test_x0();
    test_reset_mid();
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL sb_drain: got %0d writes outstanding, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
